// File: rtl/piso_tx8_if.sv
// Load handshake and serial output bundle of the piso_tx8 transmitter.
// master = word source / serial sink side, slave = transmitter.
interface piso_tx8_if #(
   parameter int W = 8
);
   logic [W-1:0] d;
   logic         load;
   logic         ready;
   logic         sout;
   logic         sout_valid;
   logic         done;

   modport master (
      output d, load,
      input  ready, sout, sout_valid, done
   );

   modport slave (
      input  d, load,
      output ready, sout, sout_valid, done
   );
endinterface

// File: rtl/piso_tx8.sv
// Parallel-in/serial-out transmitter: first bit one cycle after accept, W bits (+parity), done pulse after.
// Load is a valid/ready handshake; words offered while busy are ignored. Optional parity: PISO_TX8_PARITY_EN.
module piso_tx8 #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   piso_tx8_if.slave bus
);

   localparam int          CW   = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef PISO_TX8_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t          state_q, state_d;
   logic [W-1:0]    sr_q, sr_d, sr_shift;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ready_q, ready_d;
   logic            sout_q, sout_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;
   logic            accept;
`ifdef PISO_TX8_PARITY_EN
   logic            par_q, par_d;
`endif

   function automatic logic head(input logic [W-1:0] x);
      return MSB_FIRST ? x[W-1] : x[0];
   endfunction

   assign accept   = bus.load & ready_q;
   assign sr_shift = MSB_FIRST ? {sr_q[W-2:0], 1'b0} : {1'b0, sr_q[W-1:1]};

   // Outputs are computed one cycle ahead so every port comes straight off a flop.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      ready_d = 1'b0;
      sout_d  = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
`ifdef PISO_TX8_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = SHIFT;
               sr_d    = bus.d;
               cnt_d   = '0;
               sout_d  = head(bus.d);
               valid_d = 1'b1;
`ifdef PISO_TX8_PARITY_EN
               par_d   = ^bus.d;
`endif
            end else begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         end
         SHIFT: begin
            sr_d = sr_shift;
            if (cnt_q == LAST) begin
               cnt_d = '0;
`ifdef PISO_TX8_PARITY_EN
               state_d = PARITY;
               sout_d  = par_q;
               valid_d = 1'b1;
`else
               state_d = DONE;
               done_d  = 1'b1;
               ready_d = 1'b1;
`endif
            end else begin
               cnt_d   = cnt_q + CW'(1);
               sout_d  = head(sr_shift);
               valid_d = 1'b1;
            end
         end
`ifdef PISO_TX8_PARITY_EN
         PARITY: begin
            state_d = DONE;
            done_d  = 1'b1;
            ready_d = 1'b1;
         end
`endif
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         sout_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef PISO_TX8_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
         done_q  <= done_d;
`ifdef PISO_TX8_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.ready      = ready_q;
   assign bus.sout       = sout_q;
   assign bus.sout_valid = valid_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_tx8.sv
// Bench for piso_tx8: MSB-first and LSB-first instances share stimulus; a timestamped
// frame model fills per-instance scoreboards that a negedge monitor drains.
module tb_piso_tx8;
   localparam int W = 8;
`ifdef PISO_TX8_PARITY_EN
   localparam int F = W + 1;
`else
   localparam int F = W;
`endif

   typedef struct {
      int t;
      bit v;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] d = '0;

   ev_t q0[$];
   ev_t q1[$];
   int  dq0[$];
   int  dq1[$];
   int  cyc = 0;
   int  free_at = 0;
   int  acc_cnt = 0;
   bit  chk_en = 1'b0;
   int  errors = 0;
   int  checks = 0;

   piso_tx8_if #(.W(W)) ifm ();
   piso_tx8_if #(.W(W)) ifl ();

   assign ifm.d    = d;
   assign ifm.load = load;
   assign ifl.d    = d;
   assign ifl.load = load;

   piso_tx8 #(.W(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(ifm.slave));
   piso_tx8 #(.W(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(ifl.slave));

   always #5 clk = ~clk;

   // Frame model: an accepted word at edge e occupies windows e+1..e+F, done at e+F+1.
   task automatic accept_word(input logic [W-1:0] w, input int e);
      for (int i = 0; i < W; i++) begin
         q0.push_back('{e + 1 + i, w[W-1-i]});
         q1.push_back('{e + 1 + i, w[i]});
      end
`ifdef PISO_TX8_PARITY_EN
      q0.push_back('{e + W + 1, ^w});
      q1.push_back('{e + W + 1, ^w});
`endif
      dq0.push_back(e + F + 1);
      dq1.push_back(e + F + 1);
      free_at = e + F + 1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         q0.delete();
         q1.delete();
         dq0.delete();
         dq1.delete();
         free_at = cyc + 1;
         chk_en  = 1'b1;
      end else if (load && cyc >= free_at) begin
         accept_word(d, cyc);
         acc_cnt++;
      end
      cyc++;
   end

   task automatic cmp(input string nm, input int k, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d got=%b exp=%b", nm, k, cyc, got, exp);
      end
   endtask

   task automatic check_dut(input int k, input logic rdy, input logic so,
                            input logic sv, input logic dn);
      bit hv = 1'b0;
      bit ev = 1'b0;
      bit hd = 1'b0;
      if (k == 0) begin
         if (q0.size() > 0 && q0[0].t == cyc) begin
            hv = 1'b1; ev = q0[0].v; void'(q0.pop_front());
         end
         if (dq0.size() > 0 && dq0[0] == cyc) begin
            hd = 1'b1; void'(dq0.pop_front());
         end
      end else begin
         if (q1.size() > 0 && q1[0].t == cyc) begin
            hv = 1'b1; ev = q1[0].v; void'(q1.pop_front());
         end
         if (dq1.size() > 0 && dq1[0] == cyc) begin
            hd = 1'b1; void'(dq1.pop_front());
         end
      end
      cmp("ready", k, rdy, cyc >= free_at);
      cmp("sout_valid", k, sv, hv);
      cmp("sout", k, so, hv ? ev : 1'b0);
      cmp("done", k, dn, hd);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_dut(0, ifm.ready, ifm.sout, ifm.sout_valid, ifm.done);
         check_dut(1, ifl.ready, ifl.sout, ifl.sout_valid, ifl.done);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_accept();
      int n = acc_cnt;
      for (int i = 0; i < 50 && acc_cnt == n; i++) tick();
      checks++;
      if (acc_cnt == n) begin
         errors++;
         $display("FAIL accept_timeout cyc=%0d got=no_accept exp=accept", cyc);
      end
   endtask

   initial begin
      // Reset held with a pending load: nothing may start.
      rst = 1'b1; load = 1'b1; d = 8'b00111011;
      repeat (2) tick();
      rst = 1'b0; d = 8'b10101010;
      wait_accept();
      load = 1'b0;
      repeat (12) tick();

      d = 8'b11110000; load = 1'b1;
      wait_accept();
      load = 1'b0;
      repeat (12) tick();

      // Back-to-back: garbage offered during the frame, new word in the done cycle.
      d = 8'b00111011; load = 1'b1;
      wait_accept();
      for (int i = 0; i < 40 && cyc != free_at; i++) begin
         d = W'($urandom);
         tick();
      end
      d = 8'b11110000;
      wait_accept();
      load = 1'b0;
      repeat (14) tick();

      // Reset after three bits have gone out.
      d = 8'b10101010; load = 1'b1;
      wait_accept();
      load = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      d = 8'b00111011; load = 1'b1;
      wait_accept();
      load = 1'b0;
      repeat (12) tick();

      for (int i = 0; i < 600; i++) begin
         rst  = ($urandom_range(0, 99) < 2);
         load = $urandom_range(0, 1) == 1;
         d    = W'($urandom);
         tick();
      end
      rst = 1'b0; load = 1'b0;
      repeat (16) tick();

      checks++;
      if (q0.size() + q1.size() + dq0.size() + dq1.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d exp=0", q0.size() + q1.size() + dq0.size() + dq1.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/piso_tx8.md
Name: piso_tx8

Overview:
- Parallel-in / serial-out transmitter: takes an 8-bit word `d` (the value a `reg8`-style register presents) and shifts it out one bit per clock on `sout`.
- Acts as the serializing end of a link whose receiver is a serial-in/parallel-out register.
- Contains a word holding register, a bit counter and a 3-state FSM.
- Uses a valid/ready load handshake.

Parameters:
- W, 8, word width in bits (W >= 2).
- MSB_FIRST, 1, 1 = transmit d[W-1] first; 0 = transmit d[0] first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high; one clock; sampled on the rising edge of clk.
- d  input  W  parallel word to transmit.
- load  input  1  word valid; request to capture d.
- ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid data (or parity) bit this cycle.
- done  output  1  one-cycle pulse in the cycle after the last bit of a frame.

Behaviour:
- Reset values (rst=1 at a rising edge): state=IDLE, shift register=0, bit counter=0, ready=1, sout=0, sout_valid=0, done=0.
- Reset overrides everything, including a frame in progress.
  - The partial frame is abandoned; no done pulse.
- All outputs are registered.
- Handshake: a word is accepted at the rising edge where load=1 and ready=1.
  - load while ready=0 is ignored; nothing is queued.
  - The source must hold the word until acceptance.
- States:
  - IDLE: ready=1, sout_valid=0.
    - On accept: capture d into the shift register, counter=0, go to SHIFT.
  - SHIFT: ready=0, sout_valid=1.
    - sout = current head bit: MSB when MSB_FIRST=1, else LSB.
    - Each edge shifts the register by one position, fill 0, and increments the counter.
    - When the counter reaches W-1 at an edge: go to PARITY if PARITY_EN is defined, else go to DONE.
  - PARITY (only with PARITY_EN): ready=0, sout_valid=1, sout = even parity bit; go to DONE.
  - DONE: done=1, sout_valid=0, sout=0, ready=1.
    - Back-to-back accept in this cycle: load=1 goes directly to SHIFT with the new word.
    - Otherwise go to IDLE.
- Latency:
  - First data bit appears on sout in the cycle after acceptance.
  - Frame occupies W cycles (W+1 with parity).
  - done asserts in the following cycle.
- Throughput: one word per W+1 cycles (W+2 with parity).
- sout=0 whenever sout_valid=0.
- The counter is log2-sized, ceil(log2(W)) bits, and never wraps past W-1.

Optional Feature:
- Macro: PISO_TX8_PARITY_EN.
- Defined:
  - Even parity bit (XOR of all W captured bits) is computed at capture and sent as one extra bit after the data bits, with sout_valid=1.
  - The frame is W+1 bits.
- Undefined:
  - No PARITY state, no parity logic; the frame is exactly W bits.

Test Plan:
- Reset hold: rst=1 for 2 cycles with load=1, d=8'b00111011 -> ready=1, sout=0, sout_valid=0, done=0 throughout; no frame starts.
- Single frame, MSB_FIRST=1: release rst, load=1 for one cycle with d=8'b10101010 -> sout sequence 1,0,1,0,1,0,1,0 over 8 cycles with sout_valid=1 and ready=0; then done=1 for one cycle; then IDLE.
- LSB-first: MSB_FIRST=0, d=8'b11110000 -> sout sequence 0,0,0,0,1,1,1,1.
- Back-to-back and ignored load: load held high, d=8'b00111011 then 8'b11110000 in the DONE cycle -> second frame starts with no IDLE gap; load during SHIFT does not corrupt the frame.
- Reset mid-frame: assert rst after 3 bits of 8'b10101010 -> next edge gives ready=1, sout_valid=0, done never pulses; a fresh load transmits the full new word.
- Parity (PISO_TX8_PARITY_EN): d=8'b00111011 (five 1s) -> 8 data bits then parity bit sout=1 with sout_valid=1; d=8'b11110000 -> parity bit 0; done one cycle later.
